// File: rtl/cpc_mem_pkg.sv
// Shared types and helpers for the CPC memory responder: FSM state encoding,
// address widths and byte-lane selection for the 16-bit backing store.
package cpc_mem_pkg;

  localparam int CPC_BYTE_AW = 23;
  localparam int CPC_WORD_AW = 22;
  localparam int VRAM_AW     = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2
  } state_t;

  // Odd byte addresses live in the upper half of the 16-bit word.
  function automatic logic [1:0] lane_be(input logic odd);
    return odd ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] lane_byte(input logic odd, input logic [15:0] word);
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/cpc_mem_req_latch.sv
// Request capture for one memory source: strobe rising-edge and/or address
// change detection, plus the latched pending request handed to the FSM.
module cpc_mem_req_latch #(
  parameter int AW            = 23,
  parameter bit CHANGE_DETECT = 1'b0
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          rd,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    data,
  input  logic          take,
  output logic          pend,
  output logic          we,
  output logic [AW-1:0] addr_q,
  output logic [7:0]    data_q
);

  logic          rd_prev_reg;
  logic          wr_prev_reg;
  logic [AW-1:0] addr_prev_reg;
  logic          pend_reg;
  logic          we_reg;
  logic [AW-1:0] addr_q_reg;
  logic [7:0]    data_q_reg;

  logic rd_rise;
  logic wr_rise;
  logic addr_chg;
  logic trig;

  assign rd_rise  = rd & ~rd_prev_reg;
  assign wr_rise  = wr & ~wr_prev_reg;
  assign addr_chg = CHANGE_DETECT && (addr != addr_prev_reg);
  assign trig     = rd_rise | wr_rise | addr_chg;

  always_ff @(posedge clk) begin
    // History always follows the inputs, including during reset, so a level
    // held across reset never looks like a fresh edge afterwards.
    rd_prev_reg   <= rd;
    wr_prev_reg   <= wr;
    addr_prev_reg <= addr;
    if (srst) begin
      pend_reg   <= 1'b0;
      we_reg     <= 1'b0;
      addr_q_reg <= '0;
      data_q_reg <= '0;
    end else if (trig) begin
      // A new trigger overrides a same-cycle take: the fresher request wins.
      pend_reg   <= 1'b1;
      we_reg     <= wr_rise;
      addr_q_reg <= addr;
      if (wr_rise) begin
        data_q_reg <= data;
      end
    end else if (take) begin
      pend_reg <= 1'b0;
    end
  end

  assign pend   = pend_reg;
  assign we     = we_reg;
  assign addr_q = addr_q_reg;
  assign data_q = data_q_reg;

endmodule

// File: rtl/cpc_mem_responder.sv
// Arbitrates the CPC CPU byte port and video word port onto one word-addressed
// backing store with a req/ack handshake; video fetches take priority.
module cpc_mem_responder
  import cpc_mem_pkg::*;
#(
  parameter int ADDR_W = CPC_WORD_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CPC_BYTE_AW-1:0] mem_addr,
  input  logic                   mem_rd,
  input  logic                   mem_wr,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             cpu_din,
  input  logic [VRAM_AW-1:0]     vram_addr,
  output logic [15:0]            vram_din,
  output logic                   ram_req,
  output logic                   ram_we,
  output logic [1:0]             ram_be,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [15:0]            ram_wdata,
  input  logic                   ram_ack,
  input  logic [15:0]            ram_rdata
);

  state_t state_reg, state_next;

  logic                   cpu_pend, cpu_we;
  logic [CPC_BYTE_AW-1:0] cpu_addr;
  logic [7:0]             cpu_data;
  logic [15:0]            cpu_wdata;
  logic                   vid_pend, vid_we;
  logic [VRAM_AW-1:0]     vid_addr;
  logic [7:0]             vid_data;
  logic                   take_vid, take_cpu;

  logic              ram_req_reg,   ram_req_next;
  logic              ram_we_reg,    ram_we_next;
  logic [1:0]        ram_be_reg,    ram_be_next;
  logic [ADDR_W-1:0] ram_addr_reg,  ram_addr_next;
  logic [15:0]       ram_wdata_reg, ram_wdata_next;
  logic [7:0]        cpu_din_reg;
  logic [15:0]       vram_din_reg;

  assign take_vid = (state_reg == IDLE) && vid_pend;
  assign take_cpu = (state_reg == IDLE) && !vid_pend && cpu_pend;

  cpc_mem_req_latch #(
    .AW            (CPC_BYTE_AW),
    .CHANGE_DETECT (1'b0)
  ) u_cpu_latch (
    .clk    (clk),
    .srst   (reset),
    .rd     (mem_rd),
    .wr     (mem_wr),
    .addr   (mem_addr),
    .data   (cpu_dout),
    .take   (take_cpu),
    .pend   (cpu_pend),
    .we     (cpu_we),
    .addr_q (cpu_addr),
    .data_q (cpu_data)
  );

  // The video source never strobes, so its we/data outputs stay zero.
  cpc_mem_req_latch #(
    .AW            (VRAM_AW),
    .CHANGE_DETECT (1'b1)
  ) u_vid_latch (
    .clk    (clk),
    .srst   (reset),
    .rd     (1'b0),
    .wr     (1'b0),
    .addr   (vram_addr),
    .data   (8'h00),
    .take   (take_vid),
    .pend   (vid_pend),
    .we     (vid_we),
    .addr_q (vid_addr),
    .data_q (vid_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wlane
      assign cpu_wdata[gi*8 +: 8] = cpu_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ram_req_reg   <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_be_reg    <= 2'b00;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= 16'h0000;
      cpu_din_reg   <= 8'hFF;
      vram_din_reg  <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      ram_req_reg   <= ram_req_next;
      ram_we_reg    <= ram_we_next;
      ram_be_reg    <= ram_be_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      if (state_reg == VID && ram_ack) begin
        vram_din_reg <= ram_rdata;
      end
      // The launched byte lane is remembered in ram_be, immune to request overwrites.
      if (state_reg == CPU && ram_ack && !ram_we_reg) begin
        cpu_din_reg <= lane_byte(ram_be_reg[1], ram_rdata);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (vid_pend) begin
          state_next = VID;
        end else if (cpu_pend) begin
          state_next = CPU;
        end
      end
      VID, CPU: begin
        if (ram_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are loaded only on launch, so they hold steady while ram_req is high.
  always_comb begin
    ram_req_next   = ram_req_reg;
    ram_we_next    = ram_we_reg;
    ram_be_next    = ram_be_reg;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;
    case (state_reg)
      IDLE: begin
        if (vid_pend) begin
          ram_req_next   = 1'b1;
          ram_we_next    = vid_we;
          ram_be_next    = 2'b11;
          ram_addr_next  = ADDR_W'(vid_addr);
          ram_wdata_next = {vid_data, vid_data};
        end else if (cpu_pend) begin
          ram_req_next   = 1'b1;
          ram_we_next    = cpu_we;
          ram_be_next    = lane_be(cpu_addr[0]);
          ram_addr_next  = ADDR_W'(cpu_addr[CPC_BYTE_AW-1:1]);
          ram_wdata_next = cpu_wdata;
        end
      end
      VID, CPU: begin
        if (ram_ack) begin
          ram_req_next = 1'b0;
        end
      end
      default: ram_req_next = 1'b0;
    endcase
  end

  assign ram_req   = ram_req_reg;
  assign ram_we    = ram_we_reg;
  assign ram_be    = ram_be_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign cpu_din   = cpu_din_reg;
  assign vram_din  = vram_din_reg;

endmodule

// File: tb/tb_cpc_mem_responder.sv
// Scoreboard bench for cpc_mem_responder: stimulus queues expected requests and
// read data, a negedge monitor pops and compares as the DUT issues/completes them.
module tb_cpc_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [22:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  cpu_dout, cpu_din;
  logic [14:0] vram_addr;
  logic [15:0] vram_din;
  logic        ram_req, ram_we, ram_ack;
  logic [1:0]  ram_be;
  logic [21:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  cpc_mem_responder #(.ADDR_W(22)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .cpu_dout  (cpu_dout),
    .cpu_din   (cpu_din),
    .vram_addr (vram_addr),
    .vram_din  (vram_din),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_be    (ram_be),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_ack   (ram_ack),
    .ram_rdata (ram_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [21:0] addr;
    logic [15:0] wdata;
  } req_t;

  req_t       req_q[$];
  logic [7:0] cpu_q[$];
  logic [15:0] vid_q[$];

  int checks = 0;
  int failures = 0;
  int req_count = 0;
  int chk_kind = 0;  // 0 none, 1 video read data due, 2 cpu read data due

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [1:0] be, input logic [21:0] addr,
                          input logic [15:0] wdata);
    req_t r;
    r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  // Backing store model with programmable ack latency.
  logic [15:0] mem [0:65535];
  int   lat = 3;
  int   cnt = 0;
  logic store_ack = 1'b0;
  logic inject_ack = 1'b0;
  assign ram_ack = store_ack | inject_ack;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0091] = 16'hAB12;
    mem[16'h0020] = 16'h7700;
    mem[16'h0100] = 16'h9C33;
    mem[16'h1234] = 16'h4321;
    mem[16'h0000] = 16'hC0DE;
    mem[16'h0001] = 16'hBEEF;
    mem[16'h0002] = 16'h0A0A;
  end

  always @(posedge clk) begin
    store_ack <= 1'b0;
    if (reset) begin
      cnt <= 0;
    end else if (ram_req && !store_ack) begin
      if (cnt + 1 >= lat) begin
        cnt       <= 0;
        store_ack <= 1'b1;
        ram_rdata <= mem[ram_addr[15:0]];
        if (ram_we) begin
          if (ram_be[0]) mem[ram_addr[15:0]][7:0]  = ram_wdata[7:0];
          if (ram_be[1]) mem[ram_addr[15:0]][15:8] = ram_wdata[15:8];
        end
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  // Monitor: compare each launched request and each completed read.
  initial begin
    logic prev_req;
    logic cur_we;
    logic [1:0] cur_be;
    req_t e;
    prev_req = 1'b0; cur_we = 1'b0; cur_be = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk_kind = 0;
        prev_req = 1'b0;
      end else begin
        if (chk_kind == 1) begin
          if (vid_q.size() == 0) check("vid_unexpected_data", 32'(vram_din), 32'hFFFF_FFFF);
          else check("vram_din", 32'(vram_din), 32'(vid_q.pop_front()));
          chk_kind = 0;
        end else if (chk_kind == 2) begin
          if (cpu_q.size() == 0) check("cpu_unexpected_data", 32'(cpu_din), 32'hFFFF_FFFF);
          else check("cpu_din", 32'(cpu_din), 32'(cpu_q.pop_front()));
          chk_kind = 0;
        end
        if (ram_req && !prev_req) begin
          req_count++;
          $display("REQ t=%0t we=%0b be=%b addr=%h wdata=%h", $time, ram_we, ram_be, ram_addr, ram_wdata);
          if (req_q.size() == 0) begin
            check("unexpected_req", 32'(ram_addr), 32'hFFFF_FFFF);
          end else begin
            e = req_q.pop_front();
            check("req_we", 32'(ram_we), 32'(e.we));
            check("req_be", 32'(ram_be), 32'(e.be));
            check("req_addr", 32'(ram_addr), 32'(e.addr));
            if (e.we) check("req_wdata", 32'(ram_wdata), 32'(e.wdata));
          end
          cur_we = ram_we;
          cur_be = ram_be;
        end
        if (ram_req && ram_ack) chk_kind = cur_we ? 0 : ((cur_be == 2'b11) ? 1 : 2);
        prev_req = ram_req;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((req_q.size() != 0 || ram_req || chk_kind != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout, pending=%0d expected 0", name, req_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int base;
    logic [15:0] vexp [3];
    vexp = '{16'hC0DE, 16'hBEEF, 16'h0A0A};

    reset = 1'b1; mem_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0; cpu_dout = '0; vram_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(ram_req), 32'h0);
    check("rst_we", 32'(ram_we), 32'h0);
    check("rst_be", 32'(ram_be), 32'h0);
    check("rst_addr", 32'(ram_addr), 32'h0);
    check("rst_wdata", 32'(ram_wdata), 32'h0);
    check("rst_cpu_din", 32'(cpu_din), 32'hFF);
    check("rst_vram_din", 32'(vram_din), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_req", 32'(req_count), 32'h0);

    // CPU read of an odd byte: upper lane, launch two cycles after the edge.
    push_req(1'b0, 2'b10, 22'h000091, 16'h0); cpu_q.push_back(8'hAB);
    mem_addr = 23'h000123; mem_rd = 1'b1;
    @(negedge clk); check("launch_n1", 32'(ram_req), 32'h0);
    @(negedge clk); check("launch_n2", 32'(ram_req), 32'h1);
    mem_rd = 1'b0;
    wait_idle("cpu_read");
    check("cpu_read_final", 32'(cpu_din), 32'hAB);

    // CPU write held for 20 cycles: exactly one request, low lane only.
    base = req_count;
    push_req(1'b1, 2'b01, 22'h000020, 16'h5A5A);
    mem_addr = 23'h000040; cpu_dout = 8'h5A; mem_wr = 1'b1;
    repeat (20) @(negedge clk);
    mem_wr = 1'b0;
    wait_idle("cpu_write");
    check("wr_one_req", 32'(req_count - base), 32'h1);
    check("wr_store", 32'(mem[16'h0020]), 32'h775A);

    // Video change and CPU read edge together: video goes first.
    push_req(1'b0, 2'b11, 22'h001234, 16'h0); vid_q.push_back(16'h4321);
    push_req(1'b0, 2'b10, 22'h000100, 16'h0); cpu_q.push_back(8'h9C);
    mem_addr = 23'h000201; vram_addr = 15'h1234; mem_rd = 1'b1;
    repeat (2) @(negedge clk);
    mem_rd = 1'b0;
    wait_idle("contention");
    check("cont_vram_din", 32'(vram_din), 32'h4321);
    check("cont_cpu_din", 32'(cpu_din), 32'h9C);

    // Back-to-back video fetches with a 4-cycle store latency.
    lat = 4;
    for (int i = 0; i < 3; i++) begin
      push_req(1'b0, 2'b11, 22'(i), 16'h0); vid_q.push_back(vexp[i]);
      vram_addr = 15'(i);
      repeat (16) @(negedge clk);
    end
    wait_idle("video_b2b");
    check("b2b_vram_din", 32'(vram_din), 32'h0A0A);

    // Simultaneous read and write edges: only the write is issued.
    lat = 3;
    base = req_count;
    push_req(1'b1, 2'b10, 22'h000028, 16'h3C3C);
    mem_addr = 23'h000051; cpu_dout = 8'h3C; mem_rd = 1'b1; mem_wr = 1'b1;
    repeat (3) @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0;
    wait_idle("rd_wr_same");
    check("rdwr_one_req", 32'(req_count - base), 32'h1);
    check("rdwr_store", 32'(mem[16'h0028]), 32'h3C00);
    check("rdwr_cpu_din", 32'(cpu_din), 32'h9C);

    // Reset during an in-flight access, then a late ack.
    lat = 10;
    push_req(1'b0, 2'b01, 22'h000008, 16'h0);
    mem_addr = 23'h000010; mem_rd = 1'b1;
    begin
      int n;
      n = 0;
      while (!ram_req && n < 20) begin @(negedge clk); n++; end
      check("abort_req_seen", 32'(ram_req), 32'h1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_req_drop", 32'(ram_req), 32'h0);
    check("abort_cpu_din", 32'(cpu_din), 32'hFF);
    reset = 1'b0; mem_rd = 1'b0;
    base = req_count;
    repeat (2) @(negedge clk);
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("late_ack_cpu_din", 32'(cpu_din), 32'hFF);
    check("late_ack_vram_din", 32'(vram_din), 32'h0);
    check("late_ack_req", 32'(ram_req), 32'h0);
    check("late_ack_no_req", 32'(req_count - base), 32'h0);

    // A fresh edge after reset is served normally.
    lat = 3;
    push_req(1'b0, 2'b10, 22'h000091, 16'h0); cpu_q.push_back(8'hAB);
    mem_addr = 23'h000123; mem_rd = 1'b1;
    repeat (2) @(negedge clk);
    mem_rd = 1'b0;
    wait_idle("post_reset_read");
    check("post_reset_cpu_din", 32'(cpu_din), 32'hAB);

    check("req_q_drained", 32'(req_q.size()), 32'h0);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    check("vid_q_drained", 32'(vid_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
